wb_g18_prog: RTL
================

Name: wb_g18_prog

Overview:
Wishbone register slave that drives the write/command direction of the G18 parallel NOR flash: word program, block erase, block unlock and clear-status. Each operation issues the command bus cycles, polls the status register until ready, then returns the device to read-array mode. Sits beside the asynchronous flash read port; the top level muxes the flash pins to this block while g18_own_o=1.

Parameters:
g18_aw, 25, flash word-address width (512 Mbit / 16-bit)
wb_dw, 32, Wishbone data width
wb_aw, 32, Wishbone address width
wp_cycles, 4, clocks g18_wen_o is held low per write bus cycle (1..15)
wph_cycles, 2, clocks of high time after each write or poll read (1..15)
rd_latency, 16, clocks from g18_oen_o low to g18_dat_i sample (1..31)

Ports:
wb_clk_i  in  1  clock
wb_rstn_i  in  1  asynchronous active-low reset
wb_adr_i  in  wb_aw  register select on [3:2]
wb_dat_i  in  wb_dw  write data
wb_sel_i  in  4  byte selects; ignored, full-word access only
wb_we_i  in  1  write enable
wb_cyc_i, wb_stb_i  in  1 each  cycle / strobe
wb_ack_o  out  1  single-cycle acknowledge
wb_err_o  out  1  single-cycle error
wb_dat_o  out  wb_dw  read data
g18_dat_i  in  16  flash data in
g18_dat_o  out  16  flash data out
g18_dat_oe_o  out  1  drive g18_dat_o onto the pins
g18_adr_o  out  g18_aw  flash word address
g18_csn_o, g18_oen_o, g18_wen_o, g18_advn_o  out  1 each  flash strobes, active low
g18_own_o  out  1  pin-mux select; high while an operation runs
g18_rstn_o  out  1  equals wb_rstn_i

Behaviour:
- Registers, selected by adr[3:2]:
  - 0 ADDR: RW, [g18_aw-1:0].
  - 1 DATA: RW, [15:0].
  - 2 CTRL: W; [2:0] op: 1 program, 2 erase, 3 unlock, 4 clear-status; reads 0.
  - 3 STATUS: RO; [0] busy, [1] fail, [15:8] last status byte SR.
- Handshake:
  - Access valid = cyc & stb. Response is issued the cycle after valid is first seen, for one cycle; no response while ack_r|err_r.
  - wb_err_o instead of ack on: write to ADDR/DATA/CTRL while busy; CTRL op 0 or 5..7. An errored write has no effect.
  - Reads never error. Writes to STATUS are acked and ignored.
- Reset (async, wb_rstn_i=0):
  - csn/oen/wen/advn=1, dat_oe=0, own=0, ack=0, err=0.
  - ADDR/DATA/SR=0, busy=0, fail=0, FSM=IDLE.
  - Reset mid-operation aborts immediately and releases the pins; no read-array cycle is issued.
- FSM:
  - IDLE: on accepted CTRL write (ack cycle), set busy, load opcode pair, go WR_LO next cycle.
  - WR_LO: own=1, csn=0, advn=0, wen=0, dat_oe=1, adr=ADDR, dat_o=current command byte zero-extended (or DATA), for wp_cycles.
  - WR_HI: wen=1, advn=1, data and address still driven, for wph_cycles.
  - After WR_HI, go to the next step in the op sequence.
  - RD: csn=0, oen=0, dat_oe=0 for rd_latency clocks; sample g18_dat_i[7:0] on the last clock, then go RD_GAP (oen=1, wph_cycles).
  - After RD_GAP: if SR7=0, go RD again; else latch SR, fail = |{SR[5],SR[4],SR[3],SR[1]}, go to the 0xFF write.
  - After the 0xFF write's WR_HI, go IDLE: own=0, busy=0, csn=1.
- Op sequences:
  - Program: 0x40, DATA, poll, 0xFF.
  - Erase: 0x20, 0xD0, poll, 0xFF.
  - Unlock: 0x60, 0xD0, 0xFF; no poll, SR unchanged.
  - Clear-status: 0x50, 0xFF; SR=0, fail=0.
- Counters: one phase counter, reloaded on each state entry, 5 bits wide.
- wb_dat_o holds the last register read value. Register reads return current values while busy.

Test Plan:
1. Program: ADDR=0x12345, DATA=0xBEEF, CTRL=1; model returns SR=0x00 for 2 polls then 0x80. Required bus sequence: 0x40@0x12345, 0xBEEF@0x12345, 3 polls, 0xFF. wen low exactly 4 clocks each. STATUS ends 0x00008000. own high throughout.
2. Erase: CTRL=2 with the model failing on SR=0xA0. Required: commands 0x20 then 0xD0, then STATUS=0x0000A002 (fail=1, busy=0).
3. Busy errors: during test 1, write CTRL=2 and DATA=0x1111. Both get wb_err_o, DATA is unchanged, and the operation completes normally. A STATUS read while busy returns bit0=1 with ack.
4. Invalid op: CTRL=7 -> wb_err_o, busy stays 0, no flash strobes.
5. Clear-status after test 2: CTRL=4 -> bus cycles 0x50, 0xFF only; STATUS then reads 0x00000000.
6. Reset in the third poll of a program: drive wb_rstn_i low mid-cycle. Pins go csn=oen=wen=1, own=0 immediately, before the next clock edge. After release STATUS=0 and a new CTRL=1 runs normally.

Source files
------------

// File: rtl/wb_g18_prog.sv
`default_nettype none
// ============================================================================
// Module   : wb_g18_prog
// Purpose  : Wishbone slave sequencing G18 NOR program/erase/unlock/clear-status
//            command cycles, with status polling and return to read-array mode.
// Revision : 1.0 - initial release
// ============================================================================
module wb_g18_prog #(
  parameter int g18_aw     = 25,
  parameter int wb_dw      = 32,
  parameter int wb_aw      = 32,
  parameter int wp_cycles  = 4,
  parameter int wph_cycles = 2,
  parameter int rd_latency = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rstn_i,
  input  logic [wb_aw-1:0]  wb_adr_i,
  input  logic [wb_dw-1:0]  wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic [wb_dw-1:0]  wb_dat_o,
  input  logic [15:0]       g18_dat_i,
  output logic [15:0]       g18_dat_o,
  output logic              g18_dat_oe_o,
  output logic [g18_aw-1:0] g18_adr_o,
  output logic              g18_csn_o,
  output logic              g18_oen_o,
  output logic              g18_wen_o,
  output logic              g18_advn_o,
  output logic              g18_own_o,
  output logic              g18_rstn_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_LO  = 3'd1,
    S_WR_HI  = 3'd2,
    S_RD     = 3'd3,
    S_RD_GAP = 3'd4
  } state_t;

  localparam logic [1:0] c_k_cmd  = 2'd0;
  localparam logic [1:0] c_k_data = 2'd1;
  localparam logic [1:0] c_k_poll = 2'd2;
  localparam logic [1:0] c_k_last = 2'd3;

  localparam logic [4:0] c_wp_ld  = 5'(wp_cycles - 1);
  localparam logic [4:0] c_wph_ld = 5'(wph_cycles - 1);
  localparam logic [4:0] c_rd_ld  = 5'(rd_latency - 1);

  // Step table: {kind, command byte} for each step of each operation
  function automatic logic [9:0] f_step(input logic [2:0] op, input logic [1:0] step);
    logic [9:0] v;
    v = {c_k_last, 8'hFF};
    case (op)
      3'd1: case (step)
        2'd0:    v = {c_k_cmd,  8'h40};
        2'd1:    v = {c_k_data, 8'h00};
        2'd2:    v = {c_k_poll, 8'h00};
        default: v = {c_k_last, 8'hFF};
      endcase
      3'd2: case (step)
        2'd0:    v = {c_k_cmd,  8'h20};
        2'd1:    v = {c_k_cmd,  8'hD0};
        2'd2:    v = {c_k_poll, 8'h00};
        default: v = {c_k_last, 8'hFF};
      endcase
      3'd3: case (step)
        2'd0:    v = {c_k_cmd,  8'h60};
        2'd1:    v = {c_k_cmd,  8'hD0};
        default: v = {c_k_last, 8'hFF};
      endcase
      default: case (step)
        2'd0:    v = {c_k_cmd,  8'h50};
        default: v = {c_k_last, 8'hFF};
      endcase
    endcase
    return v;
  endfunction

  state_t            r_state, w_state_nxt;
  logic [4:0]        r_cnt, w_cnt_nxt;
  logic [1:0]        r_step, w_step_nxt;
  logic [7:0]        r_poll;
  logic              w_poll_load, w_sr_load, w_done;

  logic [g18_aw-1:0] r_addr;
  logic [15:0]       r_data;
  logic [7:0]        r_sr;
  logic              r_fail, r_busy;
  logic [2:0]        r_op;
  logic              r_ack, r_err;
  logic [wb_dw-1:0]  r_dat_o;

  logic              w_valid, w_new, w_bad;
  logic [1:0]        w_reg;
  logic [2:0]        w_op;
  logic [wb_dw-1:0]  w_rdata;
  logic [9:0]        w_cur, w_nxt;
  logic [15:0]       w_wr_dat;
  logic              w_unused;

  assign w_valid = wb_cyc_i & wb_stb_i;
  assign w_new   = w_valid & ~r_ack & ~r_err;
  assign w_reg   = wb_adr_i[3:2];
  assign w_op    = wb_dat_i[2:0];
  assign w_bad   = wb_we_i & (((w_reg != 2'd3) & r_busy) |
                              ((w_reg == 2'd2) & ((w_op == 3'd0) | (w_op > 3'd4))));

  assign w_cur    = f_step(r_op, r_step);
  assign w_nxt    = f_step(r_op, 2'(r_step + 2'd1));
  assign w_wr_dat = (w_cur[9:8] == c_k_data) ? r_data : {8'h00, w_cur[7:0]};

  assign w_unused = ^{wb_sel_i, wb_adr_i[wb_aw-1:4], wb_adr_i[1:0],
                      wb_dat_i[wb_dw-1:g18_aw], g18_dat_i[15:8], w_nxt[7:0]};

  assign wb_ack_o   = r_ack;
  assign wb_err_o   = r_err;
  assign wb_dat_o   = r_dat_o;
  assign g18_adr_o  = r_addr;
  assign g18_dat_o  = w_wr_dat;
  assign g18_rstn_o = wb_rstn_i;

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      2'd0: w_rdata[g18_aw-1:0] = r_addr;
      2'd1: w_rdata[15:0]       = r_data;
      2'd3: begin
        w_rdata[15:8] = r_sr;
        w_rdata[1]    = r_fail;
        w_rdata[0]    = r_busy;
      end
      default: w_rdata = '0;
    endcase
  end

  // Register file and Wishbone handshake
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_sr    <= '0;
      r_fail  <= 1'b0;
      r_busy  <= 1'b0;
      r_op    <= 3'd0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat_o <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      if (w_new) begin
        r_ack <= ~w_bad;
        r_err <= w_bad;
        if (!wb_we_i) begin
          r_dat_o <= w_rdata;
        end else if (!w_bad) begin
          case (w_reg)
            2'd0: r_addr <= wb_dat_i[g18_aw-1:0];
            2'd1: r_data <= wb_dat_i[15:0];
            2'd2: begin
              r_busy <= 1'b1;
              r_op   <= w_op;
              if (w_op == 3'd4) begin
                r_sr   <= '0;
                r_fail <= 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
      if (w_sr_load) begin
        r_sr   <= r_poll;
        r_fail <= |{r_poll[5], r_poll[4], r_poll[3], r_poll[1]};
      end
      if (w_done) r_busy <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_step  <= '0;
      r_poll  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_step  <= w_step_nxt;
      if (w_poll_load) r_poll <= g18_dat_i[7:0];
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = (r_cnt == 5'd0) ? 5'd0 : r_cnt - 5'd1;
    w_step_nxt   = r_step;
    w_poll_load  = 1'b0;
    w_sr_load    = 1'b0;
    w_done       = 1'b0;
    g18_csn_o    = 1'b1;
    g18_oen_o    = 1'b1;
    g18_wen_o    = 1'b1;
    g18_advn_o   = 1'b1;
    g18_dat_oe_o = 1'b0;
    g18_own_o    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_busy) begin
          w_state_nxt = S_WR_LO;
          w_cnt_nxt   = c_wp_ld;
          w_step_nxt  = 2'd0;
        end
      end
      S_WR_LO: begin
        g18_own_o    = 1'b1;
        g18_csn_o    = 1'b0;
        g18_advn_o   = 1'b0;
        g18_wen_o    = 1'b0;
        g18_dat_oe_o = 1'b1;
        if (r_cnt == 5'd0) begin
          w_state_nxt = S_WR_HI;
          w_cnt_nxt   = c_wph_ld;
        end
      end
      S_WR_HI: begin
        g18_own_o    = 1'b1;
        g18_csn_o    = 1'b0;
        g18_dat_oe_o = 1'b1;
        if (r_cnt == 5'd0) begin
          if (w_cur[9:8] == c_k_last) begin
            w_state_nxt = S_IDLE;
            w_done      = 1'b1;
          end else begin
            w_step_nxt = 2'(r_step + 2'd1);
            if (w_nxt[9:8] == c_k_poll) begin
              w_state_nxt = S_RD;
              w_cnt_nxt   = c_rd_ld;
            end else begin
              w_state_nxt = S_WR_LO;
              w_cnt_nxt   = c_wp_ld;
            end
          end
        end
      end
      S_RD: begin
        g18_own_o = 1'b1;
        g18_csn_o = 1'b0;
        g18_oen_o = 1'b0;
        if (r_cnt == 5'd0) begin
          w_poll_load = 1'b1;
          w_state_nxt = S_RD_GAP;
          w_cnt_nxt   = c_wph_ld;
        end
      end
      S_RD_GAP: begin
        g18_own_o = 1'b1;
        g18_csn_o = 1'b0;
        if (r_cnt == 5'd0) begin
          if (!r_poll[7]) begin
            w_state_nxt = S_RD;
            w_cnt_nxt   = c_rd_ld;
          end else begin
            // Device ready: capture status and move on to the read-array write
            w_sr_load   = 1'b1;
            w_step_nxt  = 2'(r_step + 2'd1);
            w_state_nxt = S_WR_LO;
            w_cnt_nxt   = c_wp_ld;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire
